// File: rtl/regfile_write_arbiter.sv
// Write-path sequencer for an enable-gated register bank: zero-fill sweep after reset,
// then round-robin arbitration of two requesters onto a single write port.
module regfile_write_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NREG   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  data_b,
  output logic              gnt_b,
  output logic [NREG-1:0]   wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              ready
);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_ptr;
  logic              last_b;
  logic              elig_a, elig_b, pick_a, pick_b;

  // Addresses at or beyond NREG decode to no enable at all.
  function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
    onehot = '0;
    for (int i = 0; i < NREG; i++)
      if (a == ADDR_W'(i)) onehot[i] = 1'b1;
  endfunction

  // A requester that was granted last cycle sits out one cycle, so a req
  // dropped on the grant edge is never granted twice.
  always_comb begin
    elig_a = req_a & ~gnt_a;
    elig_b = req_b & ~gnt_b;
    pick_a = elig_a & (~elig_b | last_b);
    pick_b = elig_b & ~pick_a;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= INIT;
      init_ptr <= '0;
      last_b   <= 1'b1;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      ready    <= 1'b0;
    end else if (state == INIT) begin
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      wr_en    <= onehot(init_ptr);
      wr_addr  <= init_ptr;
      wr_data  <= '0;
      init_ptr <= init_ptr + ADDR_W'(1);
      if (init_ptr == ADDR_W'(NREG-1)) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else begin
      gnt_a <= pick_a;
      gnt_b <= pick_b;
      if (pick_a) begin
        wr_en   <= onehot(addr_a);
        wr_addr <= addr_a;
        wr_data <= data_a;
        last_b  <= 1'b0;
      end else if (pick_b) begin
        wr_en   <= onehot(addr_b);
        wr_addr <= addr_b;
        wr_data <= data_b;
        last_b  <= 1'b1;
      end else begin
        wr_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: grant scoreboard plus directed sweep/contention/reset checks,
// and a second NREG=6 instance for out-of-range addressing.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [2:0]  addr_a = '0, addr_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        gnt_a, gnt_b, ready;
  logic [7:0]  wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;

  logic        rst6 = 1'b0, req6_a = 1'b0, req6_b = 1'b0;
  logic [2:0]  addr6_a = '0, addr6_b = '0;
  logic [31:0] data6_a = '0, data6_b = '0;
  logic        gnt6_a, gnt6_b, ready6;
  logic [5:0]  wr_en6;
  logic [2:0]  wr_addr6;
  logic [31:0] wr_data6;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.WIDTH(32), .NREG(8), .ADDR_W(3)) u_dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready));

  regfile_write_arbiter #(.WIDTH(32), .NREG(6), .ADDR_W(3)) u_dut6 (
    .clk(clk), .reset(rst6),
    .req_a(req6_a), .addr_a(addr6_a), .data_a(data6_a), .gnt_a(gnt6_a),
    .req_b(req6_b), .addr_b(addr6_b), .data_b(data6_b), .gnt_b(gnt6_b),
    .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6), .ready(ready6));

  typedef struct {
    logic        b;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [7:0]  en;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0, n_pass = 0;
  logic [31:0] bank [8];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic b, input logic [2:0] a, input logic [31:0] d);
    sb.push_back('{b, a, d, 8'd1 << a});
  endtask

  // Behavioural bank: each register captures wr_data when its enable is high.
  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (wr_en[i] === 1'b1) bank[i] <= wr_data;

  // Every grant must match the next expected write, in order.
  always @(negedge clk)
    if (gnt_a === 1'b1 || gnt_b === 1'b1) begin
      chk("gnt_excl", 64'(gnt_a & gnt_b), 0);
      if (sb.size() == 0) chk("sb_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_who", 64'(gnt_b), 64'(e.b));
        chk("sb_addr", 64'(wr_addr), 64'(e.addr));
        chk("sb_data", 64'(wr_data), 64'(e.data));
        chk("sb_en", 64'(wr_en), 64'(e.en));
      end
    end

  task automatic req_once(input logic b, input logic [2:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    push(b, a, d);
    if (b) begin req_b = 1'b1; addr_b = a; data_b = d; end
    else   begin req_a = 1'b1; addr_a = a; data_a = d; end
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = b ? gnt_b : gnt_a;
    end
    chk("gnt_timeout", 64'(got), 1);
    if (b) req_b = 1'b0; else req_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Request held through reset and the sweep must not be granted early.
    req_a = 1'b1; addr_a = 3'd3; data_a = 32'h33;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'({gnt_a, gnt_b}), 0);
    chk("rst_wren", 64'(wr_en), 0);
    chk("rst_addr", 64'(wr_addr), 0);
    chk("rst_data", 64'(wr_data), 0);
    chk("rst_ready", 64'(ready), 0);
    push(1'b0, 3'd3, 32'h33);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("init_en", 64'(wr_en), 64'(8'd1 << i));
      chk("init_addr", 64'(wr_addr), 64'(i));
      chk("init_data", 64'(wr_data), 0);
      chk("init_gnt", 64'(gnt_a), 0);
      chk("init_ready", 64'(ready), 64'(i == 7));
    end
    tick();
    chk("first_gnt", 64'(gnt_a), 1);
    req_a = 1'b0;
    tick();
    chk("first_pulse", 64'(gnt_a), 0);
    for (int i = 0; i < 8; i++)
      chk("bank_init", 64'(bank[i]), (i == 3) ? 64'h33 : 64'h0);

    // Single write
    req_once(1'b0, 3'd5, 32'd50);
    chk("sw_en", 64'(wr_en), 64'h20);
    chk("sw_addr", 64'(wr_addr), 5);
    chk("sw_data", 64'(wr_data), 50);
    tick();
    chk("sw_pulse", 64'(gnt_a), 0);
    chk("sw_bank", 64'(bank[5]), 50);

    // Leave last_grant=B ahead of contention
    req_once(1'b1, 3'd6, 32'h66);
    tick();

    // Contention: A,B,A,B
    repeat (2) begin push(1'b0, 3'd1, 32'd100); push(1'b1, 3'd2, 32'd10); end
    req_a = 1'b1; addr_a = 3'd1; data_a = 32'd100;
    req_b = 1'b1; addr_b = 3'd2; data_b = 32'd10;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("cont_a", 64'(gnt_a), 64'(i % 2 == 0));
      chk("cont_b", 64'(gnt_b), 64'(i % 2 == 1));
      chk("cont_en", 64'(wr_en), (i % 2 == 1) ? 64'h04 : 64'h02);
    end
    req_a = 1'b0; req_b = 1'b0;
    tick();
    chk("cont_idle", 64'({gnt_a, gnt_b, wr_en}), 0);

    // Single continuous requester: every other cycle
    repeat (3) push(1'b1, 3'd6, 32'h60);
    req_b = 1'b1; addr_b = 3'd6; data_b = 32'h60;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("cont_b_gnt", 64'(gnt_b), 64'(i % 2 == 0));
      if (i % 2 == 1) chk("cont_b_idle_en", 64'(wr_en), 0);
    end
    req_b = 1'b0;
    tick();
    chk("sb_drained_mid", 64'(sb.size()), 0);

    // Reset during a grant cycle
    req_once(1'b0, 3'd4, 32'h44);
    req_a = 1'b1;
    reset = 1'b0;
    req_b = 1'b1; addr_b = 3'd2; data_b = 32'h22;
    tick();
    chk("mid_rst_gnt", 64'({gnt_a, gnt_b}), 0);
    chk("mid_rst_en", 64'(wr_en), 0);
    chk("mid_rst_ready", 64'(ready), 0);
    push(1'b0, 3'd4, 32'h44);
    push(1'b1, 3'd2, 32'h22);
    reset = 1'b1;
    tick();
    chk("restart_en", 64'(wr_en), 64'h01);
    chk("restart_addr", 64'(wr_addr), 0);
    repeat (7) tick();
    chk("restart_ready", 64'(ready), 1);
    tick();
    chk("restart_first_a", 64'({gnt_a, gnt_b}), 64'b10);
    req_a = 1'b0;
    tick();
    chk("restart_then_b", 64'({gnt_a, gnt_b}), 64'b01);
    req_b = 1'b0;
    tick();
    chk("sb_drained", 64'(sb.size()), 0);

    // NREG=6 instance: six-edge sweep, then out-of-range and top in-range addresses
    rst6 = 1'b1;
    begin
      int n;
      n = 0;
      while (ready6 !== 1'b1 && n < 20) begin tick(); n++; end
      chk("n6_sweep_len", 64'(n), 6);
    end
    req6_a = 1'b1; addr6_a = 3'd7; data6_a = 32'h77;
    tick();
    chk("n6_oor_gnt", 64'(gnt6_a), 1);
    chk("n6_oor_en", 64'(wr_en6), 0);
    chk("n6_oor_addr", 64'(wr_addr6), 7);
    chk("n6_oor_data", 64'(wr_data6), 64'h77);
    addr6_a = 3'd5; data6_a = 32'h55;
    tick();
    chk("n6_gap", 64'({gnt6_a, wr_en6}), 0);
    tick();
    chk("n6_top_gnt", 64'(gnt6_a), 1);
    chk("n6_top_en", 64'(wr_en6), 64'h20);
    req6_a = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
